// File: rtl/led_bar_meter_pkg.sv
// led_bar_pkg: shared types for the LED bar meter.
//   mode_t     - display mode encoding (bar / dot), matches the 1-bit mode port.
//   pk_state_t - peak-hold FSM states (used only when LED_BAR_PEAK_HOLD_EN is defined).
package led_bar_pkg;

  typedef enum logic {
    MODE_BAR = 1'b0,
    MODE_DOT = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_HOLD  = 2'd1,
    PK_DECAY = 2'd2
  } pk_state_t;

endpackage

// File: rtl/led_bar_meter_if.sv
// led_bar_meter_if: groups the meter's control and display signals.
//   tick        - one-cycle decay-rate strobe
//   level_valid - qualifies level this cycle
//   level       - requested lit count (CW bits)
//   mode        - 0 = bar, 1 = dot
//   LEDs        - registered LED drive, bit 0 = lowest
//   peak        - registered peak-hold position
// master: the controller driving level/mode/tick; slave: the meter.
interface led_bar_meter_if #(
  parameter  int N_LEDS = 16,
  localparam int CW     = $clog2(N_LEDS + 1)
) ();

  logic              tick;
  logic              level_valid;
  logic [CW-1:0]     level;
  logic              mode;
  logic [N_LEDS-1:0] LEDs;
  logic [CW-1:0]     peak;

  modport master (
    output tick, level_valid, level, mode,
    input  LEDs, peak
  );

  modport slave (
    input  tick, level_valid, level, mode,
    output LEDs, peak
  );

endinterface

// File: rtl/led_bar_meter_therm_decoder.sv
// therm_decoder: combinational count-to-LED-pattern decode.
//   count   - number of lit positions (0..N_LEDS)
//   mode    - MODE_BAR: bits [count-1:0] set; MODE_DOT: only bit count-1 set
//   pattern - decoded LED pattern; count=0 gives all zeros in both modes
module therm_decoder
  import led_bar_pkg::*;
#(
  parameter  int N_LEDS = 16,
  localparam int CW     = $clog2(N_LEDS + 1)
) (
  input  logic [CW-1:0]     count,
  input  logic              mode,
  output logic [N_LEDS-1:0] pattern
);

  always_comb begin
    pattern = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (mode == logic'(MODE_DOT)) begin
        pattern[i] = (32'(count) == i + 1);
      end else begin
        pattern[i] = (i < 32'(count));
      end
    end
  end

endmodule

// File: rtl/led_bar_meter.sv
// led_bar_meter: bar/dot LED level meter with optional peak-hold marker.
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - led_bar_meter_if.slave (tick, level_valid, level, mode -> LEDs, peak)
// Optional feature: define LED_BAR_PEAK_HOLD_EN to build the peak-hold FSM.
// Without it, peak is constant 0, no peak LED is lit and tick is ignored.
module led_bar_meter
  import led_bar_pkg::*;
#(
  parameter int N_LEDS     = 16,
  parameter int HOLD_TICKS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  led_bar_meter_if.slave bus
);

  localparam int              CW      = $clog2(N_LEDS + 1);
  localparam logic [CW-1:0]   LVL_MAX = CW'(N_LEDS);

  logic [CW-1:0]     w_lvl_sat;
  logic [CW-1:0]     w_lvl_next;
  logic [CW-1:0]     r_level_q;
  logic [N_LEDS-1:0] w_level_pat;
  logic [N_LEDS-1:0] w_peak_pat;
  logic [N_LEDS-1:0] r_leds;

  assign w_lvl_sat  = (bus.level > LVL_MAX) ? LVL_MAX : bus.level;
  assign w_lvl_next = bus.level_valid ? w_lvl_sat : r_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= '0;
    end else if (bus.level_valid) begin
      r_level_q <= w_lvl_sat;
    end
  end

  therm_decoder #(.N_LEDS(N_LEDS)) u_level_dec (
    .count   (w_lvl_next),
    .mode    (bus.mode),
    .pattern (w_level_pat)
  );

`ifdef LED_BAR_PEAK_HOLD_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  pk_state_t     r_state;
  pk_state_t     w_state_next;
  logic [7:0]    r_hold_cnt;
  logic [7:0]    w_hold_next;
  logic [CW-1:0] r_peak;
  logic [CW-1:0] w_peak_next;
  logic [CW-1:0] w_peak_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PK_IDLE;
      r_hold_cnt <= '0;
      r_peak     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_peak     <= w_peak_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_peak_next  = r_peak;
    w_peak_dec   = r_peak - 1'b1;
    if (bus.level_valid && (w_lvl_sat >= r_peak)) begin
      // A new peak (or equal level) wins over any tick this cycle.
      w_peak_next  = w_lvl_sat;
      w_hold_next  = HOLD_INIT;
      w_state_next = (w_lvl_sat == '0) ? PK_IDLE : PK_HOLD;
    end else if (bus.level_valid && (r_state == PK_IDLE)) begin
      // Level dropped below a settled peak: leave the old peak as a held marker.
      w_hold_next  = HOLD_INIT;
      w_state_next = PK_HOLD;
    end else if (bus.tick) begin
      case (r_state)
        PK_HOLD: begin
          w_hold_next = r_hold_cnt - 1'b1;
          if (r_hold_cnt <= 8'd1) begin
            w_hold_next  = '0;
            w_state_next = PK_DECAY;
          end
        end
        PK_DECAY: begin
          // Decay never passes the current level.
          w_peak_next = (w_peak_dec > w_lvl_next) ? w_peak_dec : w_lvl_next;
          if (w_peak_next == w_lvl_next) begin
            w_state_next = PK_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  therm_decoder #(.N_LEDS(N_LEDS)) u_peak_dec (
    .count   (w_peak_next),
    .mode    (logic'(MODE_DOT)),
    .pattern (w_peak_pat)
  );

  assign bus.peak = r_peak;
`else
  assign w_peak_pat = '0;
  assign bus.peak   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leds <= '0;
    end else begin
      r_leds <= w_level_pat | w_peak_pat;
    end
  end

  assign bus.LEDs = r_leds;

endmodule

// File: tb/tb_led_bar_meter.sv
module tb_led_bar_meter;

`ifdef LED_BAR_PEAK_HOLD_EN
  localparam bit PK_EN = 1'b1;
`else
  localparam bit PK_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  led_bar_meter_if #(.N_LEDS(16)) bus ();

  led_bar_meter #(.N_LEDS(16), .HOLD_TICKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] l, input logic t, input logic m);
    bus.level_valid = v;
    bus.level       = l;
    bus.tick        = t;
    bus.mode        = m;
    @(posedge clk);
    #1;
    bus.level_valid = 1'b0;
    bus.tick        = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.level_valid = 1'b0;
    bus.level       = '0;
    bus.tick        = 1'b0;
    bus.mode        = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] e_leds;
    do_reset();
    checks++;
    if (bus.LEDs !== 16'h0000) begin
      errors++; $display("FAIL reset_leds got %h want %h", bus.LEDs, 16'h0000);
    end
    checks++;
    if (bus.peak !== 5'd0) begin
      errors++; $display("FAIL reset_peak got %0d want 0", bus.peak);
    end
    drive(1'b1, 5'd8, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h00FF) begin
      errors++; $display("FAIL pre_reset_leds got %h want %h", bus.LEDs, 16'h00FF);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.LEDs !== 16'h0000) begin
      errors++; $display("FAIL async_reset_leds got %h want %h", bus.LEDs, 16'h0000);
    end
    checks++;
    if (bus.peak !== 5'd0) begin
      errors++; $display("FAIL async_reset_peak got %0d want 0", bus.peak);
    end
    bus.level_valid = 1'b1;
    bus.level       = 5'd5;
    bus.tick        = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.LEDs !== 16'h0000) begin
      errors++; $display("FAIL reset_ignores_valid got %h want %h", bus.LEDs, 16'h0000);
    end
    bus.level_valid = 1'b0;
    bus.tick        = 1'b0;
    rst_n           = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h0000) begin
      errors++; $display("FAIL post_reset_hold got %h want %h", bus.LEDs, 16'h0000);
    end
    drive(1'b1, 5'd2, 1'b0, 1'b0);
    e_leds = 16'h0003;
    checks++;
    if (bus.LEDs !== e_leds) begin
      errors++; $display("FAIL first_capture got %h want %h", bus.LEDs, e_leds);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 5'd20, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'hFFFF) begin
      errors++; $display("FAIL sat_leds got %h want %h", bus.LEDs, 16'hFFFF);
    end
    checks++;
    if (bus.peak !== (PK_EN ? 5'd16 : 5'd0)) begin
      errors++; $display("FAIL sat_peak got %0d want %0d", bus.peak, PK_EN ? 16 : 0);
    end
    drive(1'b1, 5'd15, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== (PK_EN ? 16'hFFFF : 16'h7FFF)) begin
      errors++; $display("FAIL level15_leds got %h want %h", bus.LEDs, PK_EN ? 16'hFFFF : 16'h7FFF);
    end
    do_reset();
    drive(1'b1, 5'd31, 1'b0, 1'b1);
    checks++;
    if (bus.LEDs !== 16'h8000) begin
      errors++; $display("FAIL sat_dot_leds got %h want %h", bus.LEDs, 16'h8000);
    end
  endtask

  task automatic test_dot();
    do_reset();
    drive(1'b1, 5'd5, 1'b0, 1'b1);
    checks++;
    if (bus.LEDs !== 16'h0010) begin
      errors++; $display("FAIL dot5_leds got %h want %h", bus.LEDs, 16'h0010);
    end
    checks++;
    if (bus.peak !== (PK_EN ? 5'd5 : 5'd0)) begin
      errors++; $display("FAIL dot5_peak got %0d want %0d", bus.peak, PK_EN ? 5 : 0);
    end
    drive(1'b1, 5'd0, 1'b0, 1'b1);
    checks++;
    if (bus.LEDs !== (PK_EN ? 16'h0010 : 16'h0000)) begin
      errors++; $display("FAIL dot0_leds got %h want %h", bus.LEDs, PK_EN ? 16'h0010 : 16'h0000);
    end
    drive(1'b1, 5'd1, 1'b0, 1'b1);
    checks++;
    if (bus.LEDs !== (PK_EN ? 16'h0011 : 16'h0001)) begin
      errors++; $display("FAIL dot1_leds got %h want %h", bus.LEDs, PK_EN ? 16'h0011 : 16'h0001);
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    drive(1'b1, 5'd6, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h003F) begin
      errors++; $display("FAIL bar6_leds got %h want %h", bus.LEDs, 16'h003F);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (bus.LEDs !== 16'h0020) begin
      errors++; $display("FAIL mode_to_dot got %h want %h", bus.LEDs, 16'h0020);
    end
    drive(1'b0, 5'd9, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h003F) begin
      errors++; $display("FAIL mode_to_bar got %h want %h", bus.LEDs, 16'h003F);
    end
  endtask

  task automatic test_hold_decay();
    logic [15:0] e_leds;
    do_reset();
    drive(1'b1, 5'd10, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h03FF) begin
      errors++; $display("FAIL hd_level10 got %h want %h", bus.LEDs, 16'h03FF);
    end
    drive(1'b1, 5'd3, 1'b0, 1'b0);
`ifdef LED_BAR_PEAK_HOLD_EN
    checks++;
    if (bus.LEDs !== 16'h0207) begin
      errors++; $display("FAIL hd_level3 got %h want %h", bus.LEDs, 16'h0207);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (bus.LEDs !== 16'h0207 || bus.peak !== 5'd10) begin
        errors++; $display("FAIL hd_hold_tick%0d got %h/%0d want %h/10", k, bus.LEDs, bus.peak, 16'h0207);
      end
    end
    for (int p = 9; p >= 3; p--) begin
      drive(1'b0, 5'd0, 1'b1, 1'b0);
      e_leds = 16'h0007 | (16'h0001 << (p - 1));
      checks++;
      if (bus.LEDs !== e_leds || bus.peak !== 5'(p)) begin
        errors++; $display("FAIL hd_decay got %h/%0d want %h/%0d", bus.LEDs, bus.peak, e_leds, p);
      end
    end
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h0007 || bus.peak !== 5'd3) begin
      errors++; $display("FAIL hd_idle got %h/%0d want %h/3", bus.LEDs, bus.peak, 16'h0007);
    end
`else
    e_leds = 16'h0007;
    checks++;
    if (bus.LEDs !== e_leds || bus.peak !== 5'd0) begin
      errors++; $display("FAIL np_level3 got %h/%0d want %h/0", bus.LEDs, bus.peak, e_leds);
    end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (bus.LEDs !== e_leds || bus.peak !== 5'd0) begin
        errors++; $display("FAIL np_tick%0d got %h/%0d want %h/0", k, bus.LEDs, bus.peak, e_leds);
      end
    end
`endif
  endtask

`ifdef LED_BAR_PEAK_HOLD_EN
  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 5'd10, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) drive(1'b0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (bus.peak !== 5'd7) begin
      errors++; $display("FAIL sim_setup_peak got %0d want 7", bus.peak);
    end
    drive(1'b1, 5'd12, 1'b1, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h0FFF || bus.peak !== 5'd12) begin
      errors++; $display("FAIL sim_capture got %h/%0d want %h/12", bus.LEDs, bus.peak, 16'h0FFF);
    end
    drive(1'b1, 5'd2, 1'b0, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h0803) begin
      errors++; $display("FAIL sim_level2 got %h want %h", bus.LEDs, 16'h0803);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (bus.peak !== 5'd12) begin
        errors++; $display("FAIL sim_hold_tick%0d got %0d want 12", k, bus.peak);
      end
    end
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (bus.LEDs !== 16'h0403 || bus.peak !== 5'd11) begin
      errors++; $display("FAIL sim_first_decay got %h/%0d want %h/11", bus.LEDs, bus.peak, 16'h0403);
    end
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.level_valid = 1'b0;
    bus.level       = '0;
    bus.tick        = 1'b0;
    bus.mode        = 1'b0;
    #12;
    test_reset();
    test_saturation();
    test_dot();
    test_mode_change();
    test_hold_decay();
`ifdef LED_BAR_PEAK_HOLD_EN
    test_simultaneous();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
